// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN to honour is_signed (magnitude datapath plus sign correction on FIN entry).
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
    localparam logic [3:0] CTL_MUL = 4'b0011;
    localparam logic [3:0] CTL_DIV = 4'b0100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state_reg, state_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic               neg_a_reg, neg_a_next;
    logic               neg_b_reg, neg_b_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic               dz_reg, dz_next;

    logic use_signed;
`ifdef MULDIV_SIGNED_EN
    assign use_signed = is_signed;
`else
    assign use_signed = is_signed & 1'b0;
`endif

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = use_signed & a[WIDTH-1];
    assign b_neg = use_signed & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply keeps {partial_hi, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [2*WIDTH:0]   div_sh;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, dz_hi;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    assign mul_step = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]} : {1'b0, acc_reg[2*WIDTH-1:1]};
    assign div_sh   = {acc_reg, 1'b0};
    assign div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_reg};
    assign div_step = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                                      : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

    assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    assign quot_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    assign dz_hi    = neg_a_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        opnd_next  = opnd_reg;
        cnt_next   = cnt_reg;
        neg_a_next = neg_a_reg;
        neg_b_next = neg_b_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        dz_next    = dz_reg;
        case (state_reg)
            IDLE: begin
                if (start && !flush && (alu_ctl == CTL_MUL || alu_ctl == CTL_DIV)) begin
                    neg_a_next = a_neg;
                    neg_b_next = b_neg;
                    cnt_next   = '0;
                    if (alu_ctl == CTL_MUL) begin
                        opnd_next  = a_mag;
                        acc_next   = {{WIDTH{1'b0}}, b_mag};
                        state_next = MUL;
                    end else begin
                        opnd_next  = b_mag;
                        acc_next   = {{WIDTH{1'b0}}, a_mag};
                        state_next = DIV;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == LAST_CNT) begin
                    {hi_next, lo_next} = prod_fix;
                    dz_next    = 1'b0;
                    state_next = FIN;
                end else begin
                    acc_next = mul_step;
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DIV: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (opnd_reg == '0) begin
                    lo_next    = '1;
                    hi_next    = dz_hi;
                    dz_next    = 1'b1;
                    state_next = FIN;
                end else if (cnt_reg == LAST_CNT) begin
                    lo_next    = quot_fix;
                    hi_next    = rem_fix;
                    dz_next    = 1'b0;
                    state_next = FIN;
                end else begin
                    acc_next = div_step;
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            opnd_reg  <= '0;
            cnt_reg   <= '0;
            neg_a_reg <= 1'b0;
            neg_b_reg <= 1'b0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            dz_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            opnd_reg  <= opnd_next;
            cnt_reg   <= cnt_next;
            neg_a_reg <= neg_a_next;
            neg_b_reg <= neg_b_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            dz_reg    <= dz_next;
        end
    end

    assign busy        = (state_reg == MUL) || (state_reg == DIV);
    assign done        = (state_reg == FIN);
    assign result_lo   = lo_reg;
    assign result_hi   = hi_reg;
    assign div_by_zero = dz_reg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results are queued at issue and checked at done.
module tb_muldiv_sequencer;
    localparam int W = 32;
    localparam logic [3:0] CTL_MUL = 4'b0011;
    localparam logic [3:0] CTL_DIV = 4'b0100;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        logic [7:0]   lat;
        logic [7:0]   bsy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   alu_ctl = 4'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    exp_t sb_q[$];
    exp_t last_e = '0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctl(alu_ctl), .a(a), .b(b),
        .is_signed(is_signed), .flush(flush), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic sgn);
        exp_t e;
        logic s;
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0] pu;
        e = '0;
`ifdef MULDIV_SIGNED_EN
        s = sgn;
`else
        s = sgn & 1'b0;
`endif
        if (ctl == CTL_MUL) begin
            if (s) begin
                ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                pu = ps;
            end else begin
                pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            end
            {e.hi, e.lo} = pu;
            e.lat = 8'(W + 1);
        end else if (y == '0) begin
            e.lo  = '1;
            e.hi  = x;
            e.dz  = 1'b1;
            e.lat = 8'd1;
        end else begin
            if (s) begin
                e.lo = W'($signed(x) / $signed(y));
                e.hi = W'($signed(x) % $signed(y));
            end else begin
                e.lo = x / y;
                e.hi = x % y;
            end
            e.lat = 8'(W + 1);
        end
        e.bsy = e.lat;
        return e;
    endfunction

    // Drive a one-cycle start; operands are scrambled afterwards so latching is exercised.
    task automatic issue(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sgn, input bit push);
        @(negedge clk);
        start = 1'b1; alu_ctl = ctl; a = x; b = y; is_signed = sgn;
        if (push) sb_q.push_back(model(ctl, x, y, sgn));
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    endtask

    // Sample from the negedge after the accept edge until done, bounded by a cycle budget.
    task automatic wait_done(output exp_t got, output exp_t e, output bit ok);
        int n, bc;
        n = 0; bc = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        ok = (done === 1'b1) && (sb_q.size() > 0);
        got.lo = result_lo; got.hi = result_hi; got.dz = div_by_zero;
        got.lat = 8'(n); got.bsy = 8'(bc);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        last_e = e;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got busy=%b done=%b dz=%b exp 0 0 0", busy, done, div_by_zero);
        end
        n_checks++;
        if (result_lo !== '0 || result_hi !== '0) begin
            n_fail++;
            $display("FAIL reset_results got lo=%h hi=%h exp 0 0", result_lo, result_hi);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held got busy=%b done=%b exp 0 0", busy, done);
        end
        rst_n = 1'b1;
        $display("txn reset busy=%b done=%b lo=%h hi=%h", busy, done, result_lo, result_hi);
    endtask

    task automatic test_mul();
        logic [W-1:0] xs [5];
        logic [W-1:0] ys [5];
        exp_t got, e;
        bit ok;
        xs = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h8000_0001, 32'h1234_5678};
        ys = '{32'd6, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'd2, 32'h9ABC_DEF0};
        for (int i = 0; i < 5; i++) begin
            issue(CTL_MUL, xs[i], ys[i], 1'b0, 1'b1);
            wait_done(got, e, ok);
            n_checks++;
            if (!ok || got !== e) begin
                n_fail++;
                $display("FAIL mul_%0d got lo=%h hi=%h dz=%b lat=%0d busy=%0d exp lo=%h hi=%h dz=%b lat=%0d busy=%0d",
                         i, got.lo, got.hi, got.dz, got.lat, got.bsy, e.lo, e.hi, e.dz, e.lat, e.bsy);
            end
            $display("txn mul a=%h b=%h lo=%h hi=%h lat=%0d", xs[i], ys[i], got.lo, got.hi, got.lat);
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_pulse_%0d got done=%b busy=%b exp 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_div();
        logic [W-1:0] xs [6];
        logic [W-1:0] ys [6];
        exp_t got, e;
        bit ok;
        xs = '{32'd100, 32'd5, 32'd100, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9};
        ys = '{32'd7, 32'd0, 32'd7, 32'd1, 32'd100, 32'd2};
        for (int i = 0; i < 6; i++) begin
            issue(CTL_DIV, xs[i], ys[i], 1'b0, 1'b1);
            wait_done(got, e, ok);
            n_checks++;
            if (!ok || got !== e) begin
                n_fail++;
                $display("FAIL div_%0d got lo=%h hi=%h dz=%b lat=%0d busy=%0d exp lo=%h hi=%h dz=%b lat=%0d busy=%0d",
                         i, got.lo, got.hi, got.dz, got.lat, got.bsy, e.lo, e.hi, e.dz, e.lat, e.bsy);
            end
            $display("txn div a=%h b=%h q=%h r=%h dz=%b lat=%0d", xs[i], ys[i], got.lo, got.hi, got.dz, got.lat);
        end
    endtask

    task automatic test_signed();
        logic [3:0]   cs [5];
        logic [W-1:0] xs [5];
        logic [W-1:0] ys [5];
        exp_t got, e;
        bit ok;
        cs = '{CTL_DIV, CTL_MUL, CTL_DIV, CTL_DIV, CTL_DIV};
        xs = '{32'hFFFF_FFF9, 32'hFFFF_FFFD, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FFF9};
        ys = '{32'd2, 32'd5, 32'd7, 32'hFFFF_FFF9, 32'd0};
        for (int i = 0; i < 5; i++) begin
            issue(cs[i], xs[i], ys[i], 1'b1, 1'b1);
            wait_done(got, e, ok);
            n_checks++;
            if (!ok || got !== e) begin
                n_fail++;
                $display("FAIL signed_%0d got lo=%h hi=%h dz=%b lat=%0d busy=%0d exp lo=%h hi=%h dz=%b lat=%0d busy=%0d",
                         i, got.lo, got.hi, got.dz, got.lat, got.bsy, e.lo, e.hi, e.dz, e.lat, e.bsy);
            end
            $display("txn signed ctl=%b a=%h b=%h lo=%h hi=%h dz=%b", cs[i], xs[i], ys[i], got.lo, got.hi, got.dz);
        end
    endtask

    task automatic test_illegal();
        int bz, dn;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1; a = 32'd9; b = 32'd3;
            alu_ctl = (k == 0) ? 4'b0010 : CTL_MUL;
            flush = (k == 1);
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            bz = 0; dn = 0;
            repeat (10) begin
                if (busy !== 1'b0) bz++;
                if (done !== 1'b0) dn++;
                @(negedge clk);
            end
            n_checks++;
            if (bz != 0 || dn != 0) begin
                n_fail++;
                $display("FAIL ignored_start_%0d got busy_cycles=%0d done_cycles=%0d exp 0 0", k, bz, dn);
            end
            n_checks++;
            if (result_lo !== last_e.lo || result_hi !== last_e.hi || div_by_zero !== last_e.dz) begin
                n_fail++;
                $display("FAIL ignored_hold_%0d got lo=%h hi=%h dz=%b exp lo=%h hi=%h dz=%b",
                         k, result_lo, result_hi, div_by_zero, last_e.lo, last_e.hi, last_e.dz);
            end
            $display("txn ignored_start case=%0d busy_cycles=%0d done_cycles=%0d", k, bz, dn);
        end
    endtask

    task automatic test_flush();
        int dn;
        exp_t got, e;
        bit ok;
        issue(CTL_MUL, 32'd3, 32'd3, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy got %b exp 0", busy);
        end
        dn = 0;
        repeat (40) begin
            if (done !== 1'b0) dn++;
            @(negedge clk);
        end
        n_checks++;
        if (dn != 0 || result_lo !== last_e.lo || result_hi !== last_e.hi || div_by_zero !== last_e.dz) begin
            n_fail++;
            $display("FAIL flush_hold got dones=%0d lo=%h hi=%h dz=%b exp 0 %h %h %b",
                     dn, result_lo, result_hi, div_by_zero, last_e.lo, last_e.hi, last_e.dz);
        end
        $display("txn flush dones=%0d lo=%h hi=%h", dn, result_lo, result_hi);
        issue(CTL_MUL, 32'd11, 32'd13, 1'b0, 1'b1);
        wait_done(got, e, ok);
        n_checks++;
        if (!ok || got !== e) begin
            n_fail++;
            $display("FAIL flush_restart got lo=%h hi=%h lat=%0d exp lo=%h hi=%h lat=%0d",
                     got.lo, got.hi, got.lat, e.lo, e.hi, e.lat);
        end
        $display("txn mul_after_flush lo=%h hi=%h lat=%0d", got.lo, got.hi, got.lat);
    endtask

    task automatic test_back_to_back();
        int dn;
        exp_t got, e;
        bit ok;
        issue(CTL_DIV, 32'd1000, 32'd9, 1'b0, 1'b1);
        fork
            begin
                repeat (5) @(negedge clk);
                start = 1'b1; alu_ctl = CTL_MUL; a = 32'd2; b = 32'd3;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        wait_done(got, e, ok);
        n_checks++;
        if (!ok || got !== e) begin
            n_fail++;
            $display("FAIL busy_start got lo=%h hi=%h lat=%0d exp lo=%h hi=%h lat=%0d",
                     got.lo, got.hi, got.lat, e.lo, e.hi, e.lat);
        end
        start = 1'b1; alu_ctl = CTL_MUL; a = 32'd4; b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL fin_start got busy=%b done=%b exp 0 0", busy, done);
        end
        dn = 0;
        repeat (40) begin
            if (done !== 1'b0) dn++;
            @(negedge clk);
        end
        n_checks++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL extra_done got %0d exp 0", dn);
        end
        $display("txn div_with_ignored_starts q=%h r=%h extra_dones=%0d", got.lo, got.hi, dn);
    endtask

    task automatic test_reset_mid();
        exp_t got, e;
        bit ok;
        issue(CTL_MUL, 32'd12345, 32'd678, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        last_e = '0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || result_lo !== '0 || result_hi !== '0) begin
            n_fail++;
            $display("FAIL midop_reset got busy=%b done=%b dz=%b lo=%h hi=%h exp all 0",
                     busy, done, div_by_zero, result_lo, result_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(CTL_DIV, 32'd999, 32'd10, 1'b0, 1'b1);
        wait_done(got, e, ok);
        n_checks++;
        if (!ok || got !== e) begin
            n_fail++;
            $display("FAIL after_reset got lo=%h hi=%h lat=%0d exp lo=%h hi=%h lat=%0d",
                     got.lo, got.hi, got.lat, e.lo, e.hi, e.lat);
        end
        $display("txn div_after_reset q=%h r=%h lat=%0d", got.lo, got.hi, got.lat);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_signed();
        test_illegal();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
